// File: rtl/char_disp_pkg.sv
// char_disp_pkg: glyph geometry, code widths and commit FSM encoding shared by
// the overlay controller, its text buffer and the disp_char glyph ROM.
//   CHAR_W      glyph cell width/height in pixels
//   NUM_GLYPHS  number of codes the ROM can draw (0..NUM_GLYPHS-1)
//   BLANK_CODE  stored code meaning "no glyph"
package char_disp_pkg;
    localparam int CHAR_W     = 32;
    localparam int NUM_GLYPHS = 17;
    localparam int SEL_W      = 5;
    localparam int ROW_W      = 6;
    localparam int COL_W      = 6;
    localparam logic [SEL_W-1:0] BLANK_CODE = 5'd31;

    typedef logic [0:0] commit_state_t;
    localparam commit_state_t ST_IDLE    = 1'b0;
    localparam commit_state_t ST_PENDING = 1'b1;

    // Codes at or above NUM_GLYPHS have no ROM entry and never light a pixel.
    function automatic logic glyph_ok(input logic [SEL_W-1:0] code);
        return code < SEL_W'(NUM_GLYPHS);
    endfunction
endpackage

// File: rtl/text_dbuf.sv
// text_dbuf: double-buffered character line with commit FSM.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wr_en/addr/data shadow-buffer write port, accepted when wr_ready
//   wr_ready        low while a commit is pending (shadow frozen)
//   commit          request shadow->active copy at the next frame_start
//   frame_start     vertical-blanking pulse; the only time active changes
//   commit_pending  copy requested but not yet performed
//   rd_addr/rd_data combinational read of the active buffer
module text_dbuf #(
    parameter int NUM_CHARS = 16,
    parameter logic [char_disp_pkg::SEL_W-1:0] BLANK_CODE = char_disp_pkg::BLANK_CODE,
    localparam int AW = $clog2(NUM_CHARS)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [4:0]                      wr_addr,
    input  logic [char_disp_pkg::SEL_W-1:0] wr_data,
    output logic                            wr_ready,
    input  logic                            commit,
    input  logic                            frame_start,
    output logic                            commit_pending,
    input  logic [AW-1:0]                   rd_addr,
    output logic [char_disp_pkg::SEL_W-1:0] rd_data
);
    import char_disp_pkg::*;

    logic [SEL_W-1:0] shadow     [NUM_CHARS];
    logic [SEL_W-1:0] shadow_nxt [NUM_CHARS];
    logic [SEL_W-1:0] active     [NUM_CHARS];
    commit_state_t    state;
    logic             wr_hit;
    logic             copy;

    assign wr_ready       = (state == ST_IDLE);
    assign commit_pending = (state == ST_PENDING);
    // Six-bit compare so NUM_CHARS=32 still accepts every address.
    assign wr_hit = wr_en & wr_ready & ({1'b0, wr_addr} < 6'(NUM_CHARS));
    // A commit arriving with frame_start copies immediately, never pending.
    assign copy   = frame_start & (commit_pending | commit);
    assign rd_data = active[rd_addr];

    // The copy takes shadow_nxt so a same-cycle write is included in it.
    always_comb begin
        for (int i = 0; i < NUM_CHARS; i++)
            shadow_nxt[i] = (wr_hit && wr_addr[AW-1:0] == AW'(i)) ? wr_data : shadow[i];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            for (int i = 0; i < NUM_CHARS; i++) begin
                shadow[i] <= BLANK_CODE;
                active[i] <= BLANK_CODE;
            end
        end else begin
            state  <= copy ? ST_IDLE : (commit ? ST_PENDING : state);
            shadow <= shadow_nxt;
            if (copy) active <= shadow_nxt;
        end
    end
endmodule

// File: rtl/char_overlay_ctrl.sv
// char_overlay_ctrl: sequences the disp_char glyph ROM to overlay one line of
// NUM_CHARS characters on the VGA raster at (ORIGIN_X, ORIGIN_Y).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   pix_valid, pix_x, pix_y  pixel coordinate stream from VGA timing
//   frame_start              vertical-blanking pulse, applies pending commit
//   wr_en/addr/data, wr_ready  shadow text write port
//   commit, commit_pending   shadow->active copy request and status
//   char_sel/row/col         glyph lookup to disp_char
//   glyph_bit                disp_char output, DISP_LAT cycles after lookup
//   ovl_valid, ovl_bit       aligned pixel valid and text-colour flag
// Latency from pix_* to ovl_* is 2+DISP_LAT cycles, one pixel per cycle.
module char_overlay_ctrl #(
    parameter int NUM_CHARS = 16,
    parameter int ORIGIN_X  = 64,
    parameter int ORIGIN_Y  = 200,
    parameter int DISP_LAT  = 1,
    parameter logic [char_disp_pkg::SEL_W-1:0] BLANK_CODE = char_disp_pkg::BLANK_CODE
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            pix_valid,
    input  logic [9:0]                      pix_x,
    input  logic [9:0]                      pix_y,
    input  logic                            frame_start,
    input  logic                            wr_en,
    input  logic [4:0]                      wr_addr,
    input  logic [char_disp_pkg::SEL_W-1:0] wr_data,
    output logic                            wr_ready,
    input  logic                            commit,
    output logic                            commit_pending,
    output logic [char_disp_pkg::SEL_W-1:0] char_sel,
    output logic [char_disp_pkg::ROW_W-1:0] char_row,
    output logic [char_disp_pkg::COL_W-1:0] char_col,
    input  logic                            glyph_bit,
    output logic                            ovl_valid,
    output logic                            ovl_bit
);
    import char_disp_pkg::*;

    localparam int AW = $clog2(NUM_CHARS);

    logic [10:0]      dx;
    logic [10:0]      dy;
    logic             in_box;
    logic [AW-1:0]    idx;
    logic [SEL_W-1:0] code;
    // Index 0 is the S1 stage; higher indices wait for the ROM latency.
    logic [DISP_LAT:0] v_dl;
    logic [DISP_LAT:0] d_dl;

    // Origin checks first so below-origin pixels cannot wrap into the box.
    assign dx     = {1'b0, pix_x} - 11'(ORIGIN_X);
    assign dy     = {1'b0, pix_y} - 11'(ORIGIN_Y);
    assign in_box = (pix_x >= 10'(ORIGIN_X)) && (pix_y >= 10'(ORIGIN_Y)) &&
                    (dx < 11'(NUM_CHARS * CHAR_W)) && (dy < 11'(CHAR_W));
    assign idx    = dx[5 +: AW];

    text_dbuf #(
        .NUM_CHARS  (NUM_CHARS),
        .BLANK_CODE (BLANK_CODE)
    ) u_dbuf (
        .clk            (clk),
        .rst            (rst),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .frame_start    (frame_start),
        .commit_pending (commit_pending),
        .rd_addr        (idx),
        .rd_data        (code)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            char_sel  <= BLANK_CODE;
            char_row  <= '0;
            char_col  <= '0;
            v_dl      <= '0;
            d_dl      <= '0;
            ovl_valid <= 1'b0;
            ovl_bit   <= 1'b0;
        end else begin
            char_sel <= in_box ? code : BLANK_CODE;
            char_row <= in_box ? {1'b0, dy[4:0]} : '0;
            char_col <= in_box ? {1'b0, dx[4:0]} : '0;
            v_dl[0]  <= pix_valid;
            d_dl[0]  <= pix_valid & in_box & glyph_ok(code);
            for (int i = 1; i <= DISP_LAT; i++) begin
                v_dl[i] <= v_dl[i-1];
                d_dl[i] <= d_dl[i-1];
            end
            ovl_valid <= v_dl[DISP_LAT];
            ovl_bit   <= d_dl[DISP_LAT] & glyph_bit;
        end
    end
endmodule

// File: tb/tb_char_overlay_ctrl.sv
// tb_char_overlay_ctrl: scoreboard bench for char_overlay_ctrl with a
// one-cycle-latency stand-in for the disp_char ROM.
module tb_char_overlay_ctrl;
    import char_disp_pkg::*;

    localparam int NC  = 16;
    localparam int OX  = 64;
    localparam int OY  = 200;
    localparam int LAT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pix_valid = 1'b0;
    logic [9:0] pix_x = '0;
    logic [9:0] pix_y = '0;
    logic       frame_start = 1'b0;
    logic       wr_en = 1'b0;
    logic [4:0] wr_addr = '0;
    logic [4:0] wr_data = '0;
    logic       commit = 1'b0;
    logic       glyph_bit = 1'b0;
    logic       wr_ready, commit_pending, ovl_valid, ovl_bit;
    logic [4:0] char_sel;
    logic [5:0] char_row, char_col;
    logic       force_one = 1'b0;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [4:0] sel;
        logic [5:0] row;
        logic [5:0] col;
    } sel_t;
    typedef struct {
        logic v;
        logic b;
    } ovl_t;

    sel_t sel_q[$];
    ovl_t ovl_q[$];
    logic [4:0] m_shadow [NC];
    logic [4:0] m_active [NC];
    logic       m_pend;

    always #5 clk = ~clk;

    char_overlay_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .pix_valid      (pix_valid),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .frame_start    (frame_start),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .wr_ready       (wr_ready),
        .commit         (commit),
        .commit_pending (commit_pending),
        .char_sel       (char_sel),
        .char_row       (char_row),
        .char_col       (char_col),
        .glyph_bit      (glyph_bit),
        .ovl_valid      (ovl_valid),
        .ovl_bit        (ovl_bit)
    );

    function automatic logic gfun(input logic [4:0] s, input logic [5:0] r, input logic [5:0] c);
        return s[0] ^ r[1] ^ c[2] ^ c[0];
    endfunction

    // Glyph ROM stand-in: one cycle from lookup to glyph_bit.
    always @(posedge clk) glyph_bit <= force_one | gfun(char_sel, char_row, char_col);

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend = 1'b0;
        for (int i = 0; i < NC; i++) begin
            m_shadow[i] = BLANK_CODE;
            m_active[i] = BLANK_CODE;
        end
        sel_q.delete();
        ovl_q.delete();
    endtask

    task automatic step(input int x, input int y, input bit v, input bit we = 1'b0,
                        input int wa = 0, input int wd = 0, input bit cm = 1'b0, input bit fs = 1'b0);
        sel_t es;
        ovl_t eo;
        int   dx, dy;
        bit   inb;
        logic [4:0] code;
        @(negedge clk);
        if (sel_q.size() >= 1) begin
            es = sel_q.pop_front();
            chk("char_sel", 32'(char_sel), 32'(es.sel));
            chk("char_row", 32'(char_row), 32'(es.row));
            chk("char_col", 32'(char_col), 32'(es.col));
        end
        if (ovl_q.size() >= LAT) begin
            eo = ovl_q.pop_front();
            chk("ovl_valid", 32'(ovl_valid), 32'(eo.v));
            chk("ovl_bit", 32'(ovl_bit), 32'(eo.b));
        end
        chk("commit_pending", 32'(commit_pending), 32'(m_pend));
        chk("wr_ready", 32'(wr_ready), 32'(!m_pend));
        pix_x = 10'(x);
        pix_y = 10'(y);
        pix_valid = v;
        wr_en = we;
        wr_addr = 5'(wa);
        wr_data = 5'(wd);
        commit = cm;
        frame_start = fs;
        dx = x - OX;
        dy = y - OY;
        inb = (dx >= 0) && (dx < NC * 32) && (dy >= 0) && (dy < 32);
        code = inb ? m_active[dx / 32] : BLANK_CODE;
        es.sel = code;
        es.row = inb ? 6'(dy) : 6'd0;
        es.col = inb ? 6'(dx % 32) : 6'd0;
        eo.v = v;
        eo.b = v && inb && (code < 17) && (force_one || gfun(es.sel, es.row, es.col));
        sel_q.push_back(es);
        ovl_q.push_back(eo);
        if (we && !m_pend && wa < NC) m_shadow[wa] = 5'(wd);
        if (fs && (m_pend || cm)) begin
            m_active = m_shadow;
            m_pend = 1'b0;
        end else if (cm) begin
            m_pend = 1'b1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 1'b0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ovl_valid"}, 32'(ovl_valid), 32'd0);
        chk({tag, "_ovl_bit"}, 32'(ovl_bit), 32'd0);
        chk({tag, "_char_sel"}, 32'(char_sel), 32'(BLANK_CODE));
        chk({tag, "_char_row"}, 32'(char_row), 32'd0);
        chk({tag, "_char_col"}, 32'(char_col), 32'd0);
        chk({tag, "_commit_pending"}, 32'(commit_pending), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // Blank line: every code is BLANK_CODE, nothing lights with glyph forced on.
        force_one = 1'b1;
        for (int x = 64; x < 576; x++) step(x, 200, (x % 7) != 3);
        idle(4);
        force_one = 1'b0;

        step(0, 0, 1'b0, 1'b1, 0, 5);
        step(0, 0, 1'b0, 1'b1, 1, 16);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(2);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(1);
        step(64, 203, 1'b1);
        step(97, 203, 1'b1);
        for (int x = 64; x < 128; x++) step(x, 203, 1'b1);

        // Box edges and off-origin pixels.
        step(63, 200, 1'b1);
        step(576, 200, 1'b1);
        step(64, 232, 1'b1);
        step(64, 199, 1'b1);
        step(575, 231, 1'b1);
        step(575, 200, 1'b1);
        step(64, 200, 1'b1);
        idle(4);

        // Out-of-range slot address is dropped; slot 1 must still hold 16.
        step(0, 0, 1'b0, 1'b1, 17, 3, 1'b1, 1'b1);
        step(97, 203, 1'b1);
        step(100, 210, 1'b1);
        idle(2);

        // Commit without frame_start freezes the shadow.
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        step(0, 0, 1'b0, 1'b1, 2, 9);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(3);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        step(128, 200, 1'b1);
        step(140, 210, 1'b1);
        idle(1);

        // Write, commit and frame_start together: copy includes the write.
        step(0, 0, 1'b0, 1'b1, 3, 7, 1'b1, 1'b1);
        step(160, 210, 1'b1);
        step(191, 231, 1'b1);
        idle(4);

        // Code 20 has no glyph; then reset mid-stream.
        step(0, 0, 1'b0, 1'b1, 4, 20, 1'b1);
        step(0, 0, 1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
        idle(4);
        force_one = 1'b1;
        for (int x = 192; x < 224; x++) step(x, 205, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        wr_en = 1'b0;
        commit = 1'b0;
        frame_start = 1'b0;
        pix_valid = 1'b1;
        pix_x = 10'd200;
        pix_y = 10'd205;
        @(negedge clk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        pix_valid = 1'b0;
        model_reset();
        for (int x = 160; x < 224; x++) step(x, 205, 1'b1);
        step(64, 203, 1'b1);
        step(97, 203, 1'b1);
        idle(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
